// File: rtl/cpu_bus_pkg.sv
// Shared types and defaults for the Famicom cartridge CPU bus initiator.
package cpu_bus_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_CYC  = 1'b1
   } state_e;

   localparam int          DEF_CYCLE_CLKS  = 12;
   localparam int          DEF_M2_LOW_CLKS = 5;
   localparam logic [15:0] DEF_IDLE_ADDR   = 16'h0000;

endpackage

// File: rtl/cpu_bus_master_sync2.sv
// Two-flop synchronizer for a single asynchronous level (cartridge /IRQ);
// the reset value is a parameter so active-low lines come up deasserted.
module sync2 #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/cpu_bus_master.sv
// Famicom CPU bus initiator: turns one host request into one 2A03-style bus cycle.
// Define CPU_BUS_FREE_RUN_M2_EN to run dummy cycles while idle so M2 never stops.
module cpu_bus_master
   import cpu_bus_pkg::*;
#(
   parameter int          CYCLE_CLKS  = DEF_CYCLE_CLKS,
   parameter int          M2_LOW_CLKS = DEF_M2_LOW_CLKS,
   parameter logic [15:0] IDLE_ADDR   = DEF_IDLE_ADDR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        m2,
   output logic        romsel,
   output logic        cpu_rw,
   output logic [14:0] cpu_addr,
   output logic [7:0]  cpu_data_out,
   output logic        cpu_data_oe,
   input  logic [7:0]  cpu_data_in,
   input  logic        irq,
   output logic        irq_sync
);

   if (CYCLE_CLKS < 4 || M2_LOW_CLKS < 1 || M2_LOW_CLKS > CYCLE_CLKS - 2) begin : g_param_check
      $error("cpu_bus_master: CYCLE_CLKS or M2_LOW_CLKS out of range");
   end

   localparam int            PW         = $clog2(CYCLE_CLKS);
   localparam logic [PW-1:0] LAST_PHASE = PW'(CYCLE_CLKS - 1);
   localparam logic [PW-1:0] M2_RISE    = PW'(M2_LOW_CLKS);
   localparam logic [PW-1:0] PHASE_ONE  = PW'(1);

   state_e        state_q, state_d;
   logic [PW-1:0] phase_q, phase_d;
   logic          dummy_q, dummy_d;
   logic          a15_q, a15_d;
   logic          cpu_rw_q, cpu_rw_d;
   logic [14:0]   cpu_addr_q, cpu_addr_d;
   logic [7:0]    cpu_data_out_q, cpu_data_out_d;
   logic          m2_q, m2_d;
   logic          romsel_q, romsel_d;
   logic          oe_q, oe_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [7:0]    rsp_rdata_q, rsp_rdata_d;

   logic cyc_end;
   logic start_req;
   logic start_dummy;

   assign cyc_end   = (state_q == ST_CYC) && (phase_q == LAST_PHASE);
   assign req_ready = (state_q == ST_IDLE) || cyc_end;
   assign start_req = req_ready && req_valid;

`ifdef CPU_BUS_FREE_RUN_M2_EN
   assign start_dummy = req_ready && !req_valid;
`else
   assign start_dummy = 1'b0;
`endif

   // NOTE: every _d gets a default before any branch so no path leaves it unassigned (no latches).
   always_comb begin
      state_d        = state_q;
      phase_d        = phase_q;
      dummy_d        = dummy_q;
      a15_d          = a15_q;
      cpu_rw_d       = cpu_rw_q;
      cpu_addr_d     = cpu_addr_q;
      cpu_data_out_d = cpu_data_out_q;
      rsp_valid_d    = 1'b0;
      rsp_rdata_d    = rsp_rdata_q;

      if (cyc_end && !dummy_q) begin
         rsp_valid_d = 1'b1;
         rsp_rdata_d = cpu_rw_q ? cpu_data_in : 8'h00;
      end

      if (start_req) begin
         state_d        = ST_CYC;
         phase_d        = '0;
         dummy_d        = 1'b0;
         a15_d          = req_addr[15];
         cpu_rw_d       = ~req_write;
         cpu_addr_d     = req_addr[14:0];
         cpu_data_out_d = req_wdata;
      end else if (start_dummy) begin
         state_d    = ST_CYC;
         phase_d    = '0;
         dummy_d    = 1'b1;
         a15_d      = 1'b0;
         cpu_rw_d   = 1'b1;
         cpu_addr_d = IDLE_ADDR[14:0];
      end else if (cyc_end) begin
         state_d    = ST_IDLE;
         phase_d    = '0;
         dummy_d    = 1'b0;
         a15_d      = 1'b0;
         cpu_rw_d   = 1'b1;
         cpu_addr_d = IDLE_ADDR[14:0];
      end else if (state_q == ST_CYC) begin
         phase_d = phase_q + PHASE_ONE;
      end

      // Bus strobes are registered from the next phase so they change exactly on phase boundaries.
      m2_d     = (state_d == ST_CYC) && (phase_d >= M2_RISE);
      romsel_d = ~(m2_d & a15_d);
      oe_d     = m2_d & ~cpu_rw_d;
   end

   // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         phase_q        <= '0;
         dummy_q        <= 1'b0;
         a15_q          <= 1'b0;
         cpu_rw_q       <= 1'b1;
         cpu_addr_q     <= IDLE_ADDR[14:0];
         cpu_data_out_q <= 8'h00;
         m2_q           <= 1'b0;
         romsel_q       <= 1'b1;
         oe_q           <= 1'b0;
         rsp_valid_q    <= 1'b0;
         rsp_rdata_q    <= 8'h00;
      end else begin
         state_q        <= state_d;
         phase_q        <= phase_d;
         dummy_q        <= dummy_d;
         a15_q          <= a15_d;
         cpu_rw_q       <= cpu_rw_d;
         cpu_addr_q     <= cpu_addr_d;
         cpu_data_out_q <= cpu_data_out_d;
         m2_q           <= m2_d;
         romsel_q       <= romsel_d;
         oe_q           <= oe_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_rdata_q    <= rsp_rdata_d;
      end
   end

   assign m2           = m2_q;
   assign romsel       = romsel_q;
   assign cpu_rw       = cpu_rw_q;
   assign cpu_addr     = cpu_addr_q;
   assign cpu_data_out = cpu_data_out_q;
   assign cpu_data_oe  = oe_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_rdata    = rsp_rdata_q;

   sync2 #(
      .RESET_VAL(1'b1)
   ) u_irq_sync (
      .clk(clk),
      .rst(rst),
      .d  (irq),
      .q  (irq_sync)
   );

endmodule
